// File: rtl/first_system_sequencer.sv
// Stimulus sequencer for first_system: sweeps {in1,in2} = 00..11, holds each for
// SETTLE_CYCLES, captures both outputs. Optional truth-table compare under `SEQ_CHECK_EN.
module first_system_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [3:0]  EXP_OUT1      = 4'b1000,
  parameter logic [3:0]  EXP_OUT2      = 4'b1110
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       dut_in1,
  output logic       dut_in2,
  input  logic       dut_out1,
  input  logic       dut_out2,
  output logic [3:0] result_out1,
  output logic [3:0] result_out2,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  res1_q, res1_d;
  logic [3:0]  res2_q, res2_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  vec_q, vec_d;

  // Next-state, capture and registered-output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    res1_d  = res1_q;
    res2_d  = res2_q;
    err_d   = err_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    vec_d   = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          res1_d  = 4'b0000;
          res2_d  = 4'b0000;
          err_d   = 1'b0;
          idx_d   = 2'd0;
          cnt_d   = 8'd0;
          state_d = S_APPLY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_APPLY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        res1_d[idx_q] = dut_out1;
        res2_d[idx_q] = dut_out2;
        // The last vector exits to DONE; idx never wraps back to 0.
        if (idx_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_APPLY;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef SEQ_CHECK_EN
    // Compare against the final results, including the bit captured on this edge.
    if ((state_q == S_SAMPLE) && (state_d == S_DONE)) begin
      err_d = (res1_d != EXP_OUT1) | (res2_d != EXP_OUT2);
    end else begin
      err_d = err_d;
    end
`else
    err_d = 1'b0;
`endif

    if ((state_d == S_APPLY) || (state_d == S_SAMPLE)) begin
      busy_d = 1'b1;
      vec_d  = idx_d;
    end else begin
      busy_d = 1'b0;
      vec_d  = 2'b00;
    end
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 8'd0;
      res1_q  <= 4'b0000;
      res2_q  <= 4'b0000;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vec_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      res1_q  <= res1_d;
      res2_q  <= res2_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vec_q   <= vec_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign dut_in1     = vec_q[1];
  assign dut_in2     = vec_q[0];
  assign result_out1 = res1_q;
  assign result_out2 = res2_q;
  assign err         = err_q;

endmodule

// File: tb/tb_first_system_sequencer.sv
// Directed bench: S=4 sequencer (a) and S=1 sequencer (b), each driving an AND/OR model.
module tb_first_system_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic xor_mode = 1'b0;

  logic a_busy, a_done, a_in1, a_in2, a_out1, a_out2, a_err;
  logic [3:0] a_res1, a_res2;
  logic b_busy, b_done, b_in1, b_in2, b_out1, b_out2, b_err;
  logic [3:0] b_res1, b_res2;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_err_wrong;
  logic [1:0] exp_vec;

  always #5 clk = ~clk;

  assign a_out1 = xor_mode ? (a_in1 ^ a_in2) : (a_in1 & a_in2);
  assign a_out2 = a_in1 | a_in2;
  assign b_out1 = b_in1 & b_in2;
  assign b_out2 = b_in1 | b_in2;

  first_system_sequencer #(.SETTLE_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(a_busy), .done(a_done),
    .dut_in1(a_in1), .dut_in2(a_in2), .dut_out1(a_out1), .dut_out2(a_out2),
    .result_out1(a_res1), .result_out2(a_res2), .err(a_err)
  );

  first_system_sequencer #(.SETTLE_CYCLES(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(b_busy), .done(b_done),
    .dut_in1(b_in1), .dut_in2(b_in2), .dut_out1(b_out1), .dut_out2(b_out2),
    .result_out1(b_res1), .result_out2(b_res2), .err(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1'b1;
    start_b = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({a_busy, a_done, a_in1, a_in2, a_res1, a_res2, a_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_a got %b required 0", {a_busy, a_done, a_in1, a_in2, a_res1, a_res2, a_err});
    end
    n_tests++;
    if ({b_busy, b_done, b_in1, b_in2, b_res1, b_res2, b_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_b got %b required 0", {b_busy, b_done, b_in1, b_in2, b_res1, b_res2, b_err});
    end
    rst_n = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    tick();
    n_tests++;
    if ({a_busy, a_done, b_busy, b_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_idle got %b required 0000", {a_busy, a_done, b_busy, b_done});
    end
  endtask

  task automatic test_andor();
    xor_mode = 1'b0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k <= 21; k++) begin
      if (k > 0) tick();
      exp_vec = (k < 20) ? 2'(k / 5) : 2'b00;
      n_tests++;
      if ({a_in1, a_in2} !== exp_vec) begin
        n_fail++;
        $display("FAIL andor_vec k=%0d got %b required %b", k, {a_in1, a_in2}, exp_vec);
      end
      n_tests++;
      if (a_busy !== (k < 20)) begin
        n_fail++;
        $display("FAIL andor_busy k=%0d got %b required %b", k, a_busy, (k < 20));
      end
      n_tests++;
      if (a_done !== (k == 20)) begin
        n_fail++;
        $display("FAIL andor_done k=%0d got %b required %b", k, a_done, (k == 20));
      end
    end
    n_tests++;
    if ({a_res1, a_res2, a_err} !== {4'b1000, 4'b1110, 1'b0}) begin
      n_fail++;
      $display("FAIL andor_results got %b/%b err=%b required 1000/1110 err=0", a_res1, a_res2, a_err);
    end
  endtask

  task automatic test_wrong_model();
    bit seen;
`ifdef SEQ_CHECK_EN
    exp_err_wrong = 1'b1;
`else
    exp_err_wrong = 1'b0;
`endif
    xor_mode = 1'b1;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (a_done) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wrong_done_timeout got no done required done within 40 cycles");
    end
    n_tests++;
    if ({a_res1, a_res2, a_err} !== {4'b0110, 4'b1110, exp_err_wrong}) begin
      n_fail++;
      $display("FAIL wrong_results got %b/%b err=%b required 0110/1110 err=%b", a_res1, a_res2, a_err, exp_err_wrong);
    end
    tick();
    tick();
    n_tests++;
    if ({a_res1, a_err} !== {4'b0110, exp_err_wrong}) begin
      n_fail++;
      $display("FAIL wrong_hold got %b err=%b required 0110 err=%b", a_res1, a_err, exp_err_wrong);
    end
    xor_mode = 1'b0;
  endtask

  task automatic test_start_busy();
    int dones;
    int busy_cycles;
    dones = 0;
    busy_cycles = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (k > 0) tick();
      if (a_busy) busy_cycles++;
      if (a_done) dones++;
      start_a = (k >= 1 && k <= 18) ? 1'(k % 2) : 1'b0;
    end
    start_a = 1'b0;
    n_tests++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL busy_start_dones got %0d required 1", dones);
    end
    n_tests++;
    if (busy_cycles !== 20) begin
      n_fail++;
      $display("FAIL busy_start_len got %0d required 20", busy_cycles);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    dones = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    n_tests++;
    if ({a_in1, a_in2, a_res2} !== {2'b10, 4'b0010}) begin
      n_fail++;
      $display("FAIL midrst_pre got vec=%b res2=%b required vec=10 res2=0010", {a_in1, a_in2}, a_res2);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if ({a_busy, a_done, a_in1, a_in2, a_res1, a_res2, a_err} !== 13'd0) begin
      n_fail++;
      $display("FAIL midrst_clear got %b required 0", {a_busy, a_done, a_in1, a_in2, a_res1, a_res2, a_err});
    end
    for (int k = 0; k < 25; k++) begin
      tick();
      if (a_done || a_busy) dones++;
    end
    n_tests++;
    if (dones !== 0) begin
      n_fail++;
      $display("FAIL midrst_quiet got %0d active cycles required 0", dones);
    end
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 20; k++) tick();
    n_tests++;
    if ({a_done, a_res1, a_res2, a_err} !== {1'b1, 4'b1000, 4'b1110, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_rerun got done=%b %b/%b err=%b required done=1 1000/1110 err=0", a_done, a_res1, a_res2, a_err);
    end
    tick();
  endtask

  task automatic test_s1();
    bit seen;
    start_b = 1'b1;
    tick();
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) tick();
      exp_vec = (k < 8) ? 2'(k / 2) : 2'b00;
      n_tests++;
      if ({b_in1, b_in2} !== exp_vec) begin
        n_fail++;
        $display("FAIL s1_vec k=%0d got %b required %b", k, {b_in1, b_in2}, exp_vec);
      end
      n_tests++;
      if (b_busy !== ((k < 8) || (k == 10))) begin
        n_fail++;
        $display("FAIL s1_busy k=%0d got %b required %b", k, b_busy, ((k < 8) || (k == 10)));
      end
      n_tests++;
      if (b_done !== (k == 8)) begin
        n_fail++;
        $display("FAIL s1_done k=%0d got %b required %b", k, b_done, (k == 8));
      end
      if (k == 8) begin
        n_tests++;
        if ({b_res1, b_res2, b_err} !== {4'b1000, 4'b1110, 1'b0}) begin
          n_fail++;
          $display("FAIL s1_results got %b/%b err=%b required 1000/1110 err=0", b_res1, b_res2, b_err);
        end
      end
    end
    start_b = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (b_done) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL s1_second_done got no done required done within 20 cycles");
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_andor();
    test_wrong_model();
    test_start_busy();
    test_reset_mid();
    test_s1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/first_system_sequencer.md
# first_system_sequencer

Hardware stimulus sequencer for the `first_system` two-input, two-output datapath.
On a start request it drives each of the four input vectors `{in1,in2}` = 00, 01, 10, 11 onto the datapath in turn. It holds each vector for a programmable settle time, so propagation delays in the dataflow variant are absorbed, then samples both outputs into result registers. It sits between a control source (button or host register) and the `first_system` instance, replacing the simulation-only stimulus with on-chip sequencing.

## Interface
Parameters:
- `SETTLE_CYCLES`, 4: cycles each vector is held before sampling. Legal range 1..255.
- `EXP_OUT1`, 4'b1000: expected `out1` truth table. Bit i is the expected value for vector i = `{in1,in2}`. Used only with `SEQ_CHECK_EN`.
- `EXP_OUT2`, 4'b1110: expected `out2` truth table, same indexing. Used only with `SEQ_CHECK_EN`.

Ports:
- `clk`  in  1  system clock. All logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  run request. Sampled only in IDLE.
- `busy`  out  1  high in APPLY and SAMPLE.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `dut_in1`  out  1  drives `first_system.in1`.
- `dut_in2`  out  1  drives `first_system.in2`.
- `dut_out1`  in  1  from `first_system.out1`.
- `dut_out2`  in  1  from `first_system.out2`.
- `result_out1`  out  4  sampled `out1`. Bit i corresponds to vector i.
- `result_out2`  out  4  sampled `out2`. Bit i corresponds to vector i.
- `err`  out  1  sweep mismatch flag. Constant 0 without `SEQ_CHECK_EN`.

## Operation
- The state machine has four states: IDLE, APPLY, SAMPLE, DONE. Internal registers:
  - `idx` (2 bits): current vector index.
  - `cnt` (8 bits): settle counter.
- **IDLE**
  - If `start`=1: clear `result_out1`, `result_out2` and `err`, set `idx`=0 and `cnt`=0, then go to APPLY.
  - Otherwise remain in IDLE.
- **APPLY**
  - `{dut_in1,dut_in2}` = `idx`.
  - `cnt` increments each cycle.
  - When `cnt`==`SETTLE_CYCLES`-1, go to SAMPLE and clear `cnt`.
- **SAMPLE**
  - Keep driving vector `idx`.
  - On the exiting edge, write `result_out1[idx]`=`dut_out1` and `result_out2[idx]`=`dut_out2`.
  - If `idx`==3, go to DONE. Otherwise increment `idx` and go to APPLY.
- **DONE**
  - `done`=1 for exactly this cycle, then go to IDLE.
- `dut_in1` and `dut_in2` are 0 in IDLE and DONE.
- `start` is ignored outside IDLE; no queuing. `start` held high continuously causes back-to-back sweeps with one IDLE cycle between them.
- Results and `err` hold their values from DONE until the next accepted `start`.
- `idx` does not wrap. Exit from SAMPLE at `idx`==3 is to DONE, never to vector 0.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `dut_in1`=0, `dut_in2`=0, `result_out1`=0, `result_out2`=0, `err`=0. State is IDLE, `idx`=0, `cnt`=0.
- Let `start` be accepted at edge 0, with S = `SETTLE_CYCLES`.
  - `busy` rises after edge 0.
  - Vector i is driven from edge i(S+1) to edge (i+1)(S+1).
  - Vector i is captured at edge (i+1)(S+1).
  - `busy` falls and `done` rises after edge 4(S+1). `done` falls one edge later.
- Total sweep: 4(S+1)+1 cycles, including the DONE cycle.
- A dataflow delay in `first_system` must be below S clock periods. This is an integration requirement, not checked by the block.
- Reset mid-sweep (`rst_n`=0 at any edge): immediate return to reset values, no `done` pulse, partial results discarded.
- `start` and `rst_n`=0 at the same edge: reset wins.

## Configuration
- Macro: `SEQ_CHECK_EN`.
- Defined: on the edge entering DONE, `err` is set to `(result_out1 != EXP_OUT1) | (result_out2 != EXP_OUT2)`. The compare uses the final values, including the bit captured on that same edge. `err` is valid while `done`=1 and holds afterwards.
- Undefined: no compare logic is built, `err` is tied to 0, and `EXP_OUT1`/`EXP_OUT2` are unused.

## Test plan
- **Reset:** `rst_n`=0 for 2 cycles with `start`=1 → all outputs 0, state IDLE, no `done` pulse.
- **AND/OR model, S=4:** pulse `start` with the model attached → `dut_in` steps 00, 01, 10, 11 every 5 cycles. `done` pulses at cycle 20 after acceptance. `result_out1`=4'b1000, `result_out2`=4'b1110, `err`=0 (with `SEQ_CHECK_EN`).
- **Wrong model (XOR on `out1`):** run a sweep → `result_out1`=4'b0110. `err`=1 with `SEQ_CHECK_EN`; `err`=0 without it.
- **Start while busy:** extra `start` pulses during APPLY and SAMPLE → exactly one `done` pulse and an unchanged sweep length.
- **Reset mid-sweep:** assert `rst_n`=0 during vector 2 → outputs return to reset values, no `done` pulse. A new `start` runs a full sweep correctly.
- **S=1 boundary:** each vector is held 2 cycles and `done` pulses at cycle 8. Holding `start` high gives the next sweep's `busy` one cycle after `done`.
